seven_seg_scan_capture: RTL and testbench

SEVEN_SEG_SCAN_CAPTURE -- requirements
Module: seven_seg_scan_capture

---
 rtl/seven_seg_scan_capture.sv | 160 ++++++++++++++++
 tb/tb_seven_seg_scan_capture.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan_capture.sv
// Watches a multiplexed 4-digit seven-segment drive and rebuilds the displayed text as ASCII,
// flagging new frames, changes, one-character left scrolls and a blanked (idle) display.
module seven_seg_scan_capture #(
   parameter int unsigned SETTLE_CYCLES = 4,
   parameter int unsigned IDLE_CYCLES   = 1000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [0:6]  seg,
   input  logic [3:0]  an,
   output logic [31:0] chars,
   output logic        frameValid,
   output logic        frameChanged,
   output logic        scrollStep,
   output logic [7:0]  scrollCount,
   output logic        displayIdle
);

   localparam int unsigned SETTLE_W = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);
   localparam int unsigned IDLE_W   = (IDLE_CYCLES < 1) ? 1 : $clog2(IDLE_CYCLES + 1);
   localparam int unsigned SAMPLE_W = 11;
   localparam logic [SETTLE_W-1:0] SETTLE_MAX = SETTLE_W'(SETTLE_CYCLES);
   localparam logic [IDLE_W-1:0]   IDLE_MAX   = IDLE_W'(IDLE_CYCLES);

   function automatic logic [7:0] decodeSeg(input logic [6:0] p);
      logic [7:0] ch;
      case (p)
         7'h7E:   ch = 8'h30;
         7'h30:   ch = 8'h31;
         7'h6D:   ch = 8'h32;
         7'h79:   ch = 8'h33;
         7'h33:   ch = 8'h34;
         7'h5B:   ch = 8'h35;
         7'h5F:   ch = 8'h36;
         7'h70:   ch = 8'h37;
         7'h7F:   ch = 8'h38;
         7'h7B:   ch = 8'h39;
         7'h00:   ch = 8'h20;
         7'h01:   ch = 8'h2D;
         default: ch = 8'h3F;
      endcase
      return ch;
   endfunction

   logic [SAMPLE_W-1:0] sample, prevSample;
   logic [SETTLE_W-1:0] settleCnt, settleNext;
   logic [IDLE_W-1:0]   idleCnt, idleNext;
   logic [3:0]          flags, flagsNext;
   logic [3:0][7:0]     buffer, bufferNext;
   logic [31:0]         charsNext;
   logic [7:0]          scrollNext;
   logic [6:0]          pattern;
   logic [1:0]          slot;
   logic                sampleValid, stable, accept, idleHit, frameDone;
   logic                firstFrame, firstNext;
   logic                fvNext, fcNext, ssNext;

   // Anode decode: only a single low anode selects a slot
   always_comb begin
      sampleValid = 1'b0;
      slot        = 2'd0;
      case (an)
         4'b0111: begin sampleValid = 1'b1; slot = 2'd3; end
         4'b1011: begin sampleValid = 1'b1; slot = 2'd2; end
         4'b1101: begin sampleValid = 1'b1; slot = 2'd1; end
         4'b1110: begin sampleValid = 1'b1; slot = 2'd0; end
         default: begin sampleValid = 1'b0; slot = 2'd0; end
      endcase
   end

   assign sample  = {an, seg};
   assign pattern = {~seg[0], ~seg[1], ~seg[2], ~seg[3], ~seg[4], ~seg[5], ~seg[6]};

   // Next-state: settle/accept, idle detection, working buffer and frame publication
   always_comb begin
      settleNext = '0;
      stable     = 1'b0;
      accept     = 1'b0;
      idleNext   = '0;
      idleHit    = 1'b0;
      flagsNext  = flags;
      bufferNext = buffer;
      charsNext  = chars;
      fvNext     = 1'b0;
      fcNext     = 1'b0;
      ssNext     = 1'b0;
      scrollNext = scrollCount;
      firstNext  = firstFrame;
      frameDone  = &flags;

      if (sampleValid) begin
         stable = (settleCnt != '0) && (sample == prevSample);
         if (stable) begin
            settleNext = (settleCnt == SETTLE_MAX) ? settleCnt : settleCnt + SETTLE_W'(1);
         end else begin
            settleNext = SETTLE_W'(1);
         end
         // A saturated counter on an unchanged sample means this dwell was already taken
         accept = (settleNext == SETTLE_MAX) && !(stable && (settleCnt == SETTLE_MAX));
      end

      if (an == 4'hF) begin
         idleNext = (idleCnt == IDLE_MAX) ? idleCnt : idleCnt + IDLE_W'(1);
      end
      idleHit = (idleNext == IDLE_MAX);

      if (frameDone) begin
         flagsNext  = '0;
         charsNext  = buffer;
         fvNext     = 1'b1;
         fcNext     = firstFrame || (buffer != chars);
         ssNext     = !firstFrame && fcNext && (buffer[3:1] == chars[23:0]);
         firstNext  = 1'b0;
         if (ssNext && (scrollCount != 8'hFF)) begin
            scrollNext = scrollCount + 8'd1;
         end
      end

      if (accept) begin
         flagsNext[slot]  = 1'b1;
         bufferNext[slot] = decodeSeg(pattern);
      end

      if (idleHit) begin
         flagsNext = '0;
      end
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         prevSample   <= '0;
         settleCnt    <= '0;
         idleCnt      <= '0;
         flags        <= '0;
         buffer       <= {4{8'h20}};
         firstFrame   <= 1'b1;
         chars        <= 32'h20202020;
         frameValid   <= 1'b0;
         frameChanged <= 1'b0;
         scrollStep   <= 1'b0;
         scrollCount  <= 8'd0;
         displayIdle  <= 1'b0;
      end else begin
         prevSample   <= sample;
         settleCnt    <= settleNext;
         idleCnt      <= idleNext;
         flags        <= flagsNext;
         buffer       <= bufferNext;
         firstFrame   <= firstNext;
         chars        <= charsNext;
         frameValid   <= fvNext;
         frameChanged <= fcNext;
         scrollStep   <= ssNext;
         scrollCount  <= scrollNext;
         displayIdle  <= idleHit;
      end
   end

endmodule

// File: tb/tb_seven_seg_scan_capture.sv
// Directed bench for seven_seg_scan_capture: scans hand-built digit patterns and checks
// the rebuilt frame, pulse outputs, idle detection and reset behaviour.
module tb_seven_seg_scan_capture;

   localparam logic [6:0] P0 = 7'h7E, P1 = 7'h30, P2 = 7'h6D, P3 = 7'h79, P4 = 7'h33;
   localparam logic [6:0] P5 = 7'h5B, P6 = 7'h5F, P7 = 7'h70, P8 = 7'h7F, P9 = 7'h7B;
   localparam logic [6:0] PBLANK = 7'h00, PDASH = 7'h01, PJUNK = 7'h2A;

   logic        clk = 1'b0;
   logic        reset;
   logic [0:6]  seg;
   logic [3:0]  an;
   logic [31:0] chars;
   logic        frameValid, frameChanged, scrollStep, displayIdle;
   logic [7:0]  scrollCount;

   int errors = 0;
   int checks = 0;
   int fvCnt = 0, fcCnt = 0, ssCnt = 0;

   always #5 clk = ~clk;

   seven_seg_scan_capture #(.SETTLE_CYCLES(4), .IDLE_CYCLES(1000)) dut (
      .clk(clk), .reset(reset), .seg(seg), .an(an), .chars(chars),
      .frameValid(frameValid), .frameChanged(frameChanged), .scrollStep(scrollStep),
      .scrollCount(scrollCount), .displayIdle(displayIdle)
   );

   // Advance n cycles, sampling pulses on each falling edge
   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (frameValid)   fvCnt++;
         if (frameChanged) fcCnt++;
         if (scrollStep)   ssCnt++;
      end
   endtask

   task automatic dwell(input logic [3:0] a, input logic [6:0] p, input int n);
      an  = a;
      seg = ~p;
      step(n);
   endtask

   task automatic scan(input logic [6:0] p3, input logic [6:0] p2, input logic [6:0] p1,
                       input logic [6:0] p0, input int n);
      dwell(4'h7, p3, n);
      dwell(4'hB, p2, n);
      dwell(4'hD, p1, n);
      dwell(4'hE, p0, n);
   endtask

   task automatic test_reset;
      reset = 1'b1; an = 4'hF; seg = 7'h7F;
      step(2);
      checks++; if (chars !== 32'h20202020) begin errors++; $display("FAIL reset_chars got %h want 20202020", chars); end
      checks++; if (frameValid !== 1'b0) begin errors++; $display("FAIL reset_fv got %b want 0", frameValid); end
      checks++; if (frameChanged !== 1'b0) begin errors++; $display("FAIL reset_fc got %b want 0", frameChanged); end
      checks++; if (scrollStep !== 1'b0) begin errors++; $display("FAIL reset_ss got %b want 0", scrollStep); end
      checks++; if (scrollCount !== 8'd0) begin errors++; $display("FAIL reset_sc got %0d want 0", scrollCount); end
      checks++; if (displayIdle !== 1'b0) begin errors++; $display("FAIL reset_idle got %b want 0", displayIdle); end
      reset = 1'b0;
   endtask

   task automatic test_short_dwell;
      int fv0;
      fv0 = fvCnt;
      scan(P1, P2, P3, P4, 3);
      scan(P1, P2, P3, P4, 3);
      checks++; if (fvCnt - fv0 !== 0) begin errors++; $display("FAIL short_dwell_fv got %0d want 0", fvCnt - fv0); end
      checks++; if (chars !== 32'h20202020) begin errors++; $display("FAIL short_dwell_chars got %h want 20202020", chars); end
   endtask

   task automatic test_first_frame;
      dwell(4'h7, P1, 8);
      dwell(4'hB, P2, 8);
      dwell(4'hD, P3, 8);
      an = 4'hE; seg = ~P4;
      for (int k = 1; k <= 5; k++) begin
         step(1);
         checks++;
         if (frameValid !== (k == 5)) begin errors++; $display("FAIL latency_fv cycle %0d got %b want %b", k, frameValid, (k == 5)); end
         if (k == 4) begin
            checks++; if (chars !== 32'h20202020) begin errors++; $display("FAIL early_chars got %h want 20202020", chars); end
         end
         if (k == 5) begin
            checks++; if (chars !== 32'h31323334) begin errors++; $display("FAIL first_chars got %h want 31323334", chars); end
            checks++; if (frameChanged !== 1'b1) begin errors++; $display("FAIL first_fc got %b want 1", frameChanged); end
            checks++; if (scrollStep !== 1'b0) begin errors++; $display("FAIL first_ss got %b want 0", scrollStep); end
         end
      end
      step(3);
   endtask

   task automatic test_rescan_scroll;
      int fv0, fc0, ss0;
      fv0 = fvCnt; fc0 = fcCnt; ss0 = ssCnt;
      scan(P1, P2, P3, P4, 8);
      checks++; if (fvCnt - fv0 !== 1) begin errors++; $display("FAIL rescan_fv got %0d want 1", fvCnt - fv0); end
      checks++; if (fcCnt - fc0 !== 0) begin errors++; $display("FAIL rescan_fc got %0d want 0", fcCnt - fc0); end
      checks++; if (ssCnt - ss0 !== 0) begin errors++; $display("FAIL rescan_ss got %0d want 0", ssCnt - ss0); end
      fc0 = fcCnt; ss0 = ssCnt;
      scan(P2, P3, P4, P5, 8);
      checks++; if (fcCnt - fc0 !== 1) begin errors++; $display("FAIL scroll_fc got %0d want 1", fcCnt - fc0); end
      checks++; if (ssCnt - ss0 !== 1) begin errors++; $display("FAIL scroll_ss got %0d want 1", ssCnt - ss0); end
      checks++; if (scrollCount !== 8'd1) begin errors++; $display("FAIL scroll_count got %0d want 1", scrollCount); end
      checks++; if (chars !== 32'h32333435) begin errors++; $display("FAIL scroll_chars got %h want 32333435", chars); end
   endtask

   task automatic test_recapture;
      int fv0, ss0;
      fv0 = fvCnt; ss0 = ssCnt;
      dwell(4'h7, P5, 8);
      dwell(4'hB, P5, 8);
      dwell(4'hB, P7, 8);
      dwell(4'hD, P0, 8);
      dwell(4'hE, P0, 8);
      checks++; if (fvCnt - fv0 !== 1) begin errors++; $display("FAIL recapture_fv got %0d want 1", fvCnt - fv0); end
      checks++; if (chars !== 32'h35373030) begin errors++; $display("FAIL recapture_chars got %h want 35373030", chars); end
      checks++; if (ssCnt - ss0 !== 0) begin errors++; $display("FAIL recapture_ss got %0d want 0", ssCnt - ss0); end
   endtask

   task automatic test_invalid;
      int fv0;
      fv0 = fvCnt;
      dwell(4'hD, P0, 8);
      dwell(4'hE, PDASH, 8);
      dwell(4'b0011, P8, 8);
      dwell(4'h7, P9, 8);
      dwell(4'hB, PJUNK, 8);
      checks++; if (fvCnt - fv0 !== 1) begin errors++; $display("FAIL invalid_fv got %0d want 1", fvCnt - fv0); end
      checks++; if (chars !== 32'h393F302D) begin errors++; $display("FAIL invalid_chars got %h want 393F302D", chars); end
      checks++; if (scrollCount !== 8'd1) begin errors++; $display("FAIL invalid_sc got %0d want 1", scrollCount); end
   endtask

   task automatic test_idle;
      int fv0;
      fv0 = fvCnt;
      dwell(4'h7, P1, 8);
      dwell(4'hB, P2, 8);
      an = 4'hF; seg = 7'h7F;
      step(999);
      checks++; if (displayIdle !== 1'b0) begin errors++; $display("FAIL idle_999 got %b want 0", displayIdle); end
      step(1);
      checks++; if (displayIdle !== 1'b1) begin errors++; $display("FAIL idle_1000 got %b want 1", displayIdle); end
      checks++; if (chars !== 32'h393F302D) begin errors++; $display("FAIL idle_chars got %h want 393F302D", chars); end
      dwell(4'hD, P3, 1);
      checks++; if (displayIdle !== 1'b0) begin errors++; $display("FAIL idle_exit got %b want 0", displayIdle); end
      step(7);
      dwell(4'hE, P4, 8);
      checks++; if (fvCnt - fv0 !== 0) begin errors++; $display("FAIL idle_partial_fv got %0d want 0", fvCnt - fv0); end
      dwell(4'h7, P5, 8);
      dwell(4'hB, P6, 8);
      checks++; if (fvCnt - fv0 !== 1) begin errors++; $display("FAIL idle_full_fv got %0d want 1", fvCnt - fv0); end
      checks++; if (chars !== 32'h35363334) begin errors++; $display("FAIL idle_chars_new got %h want 35363334", chars); end
   endtask

   task automatic test_reset_mid_frame;
      int fv0, fc0, ss0;
      dwell(4'h7, P1, 8);
      dwell(4'hB, P2, 8);
      reset = 1'b1;
      step(2);
      checks++; if (chars !== 32'h20202020) begin errors++; $display("FAIL midreset_chars got %h want 20202020", chars); end
      checks++; if (scrollCount !== 8'd0) begin errors++; $display("FAIL midreset_sc got %0d want 0", scrollCount); end
      reset = 1'b0;
      fv0 = fvCnt; fc0 = fcCnt; ss0 = ssCnt;
      dwell(4'hD, P9, 8);
      dwell(4'hE, P9, 8);
      checks++; if (fvCnt - fv0 !== 0) begin errors++; $display("FAIL midreset_partial_fv got %0d want 0", fvCnt - fv0); end
      dwell(4'h7, P9, 8);
      dwell(4'hB, P9, 8);
      checks++; if (fvCnt - fv0 !== 1) begin errors++; $display("FAIL midreset_fv got %0d want 1", fvCnt - fv0); end
      checks++; if (chars !== 32'h39393939) begin errors++; $display("FAIL midreset_chars_new got %h want 39393939", chars); end
      checks++; if (fcCnt - fc0 !== 1) begin errors++; $display("FAIL midreset_fc got %0d want 1", fcCnt - fc0); end
      checks++; if (ssCnt - ss0 !== 0) begin errors++; $display("FAIL midreset_ss got %0d want 0", ssCnt - ss0); end
   endtask

   task automatic test_first_blank;
      int fv0, fc0, ss0;
      reset = 1'b1;
      step(2);
      reset = 1'b0;
      fv0 = fvCnt; fc0 = fcCnt; ss0 = ssCnt;
      scan(PBLANK, PBLANK, PBLANK, PBLANK, 8);
      checks++; if (fcCnt - fc0 !== 1) begin errors++; $display("FAIL blank_first_fc got %0d want 1", fcCnt - fc0); end
      checks++; if (ssCnt - ss0 !== 0) begin errors++; $display("FAIL blank_first_ss got %0d want 0", ssCnt - ss0); end
      checks++; if (chars !== 32'h20202020) begin errors++; $display("FAIL blank_chars got %h want 20202020", chars); end
      scan(PBLANK, PBLANK, PBLANK, PBLANK, 8);
      checks++; if (fvCnt - fv0 !== 2) begin errors++; $display("FAIL blank_fv got %0d want 2", fvCnt - fv0); end
      checks++; if (fcCnt - fc0 !== 1) begin errors++; $display("FAIL blank_second_fc got %0d want 1", fcCnt - fc0); end
   endtask

   initial begin
      reset = 1'b1;
      an    = 4'hF;
      seg   = 7'h7F;
      test_reset();
      test_short_dwell();
      test_first_frame();
      test_rescan_scroll();
      test_recapture();
      test_invalid();
      test_idle();
      test_reset_mid_frame();
      test_first_blank();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
